rom_fetch_unit: RTL and testbench
=================================

Name: rom_fetch_unit

Overview:
- Program-counter and fetch stage that sits directly upstream of the program ROM (12-bit address, 8-bit data).
- Drives the ROM address from an internal program counter and captures the returned byte into an instruction register.
- Splits the captured byte into an instruction nibble and an operand nibble.
- Sequences fetch/execute phases for the downstream decode logic, with run, single-step and jump support.

Parameters:
AW, 12, ROM address width / program counter width
DW, 8, ROM data width; must be even; instr = upper DW/2 bits, oprnd = lower DW/2 bits

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  level; 1 = free-running fetch/execute cycling
step  input  1  one-cycle pulse; performs exactly one FETCH+EXEC pair while run=0
load_pc  input  1  jump request; PC <= load_addr (see Behaviour for when it is honoured)
load_addr  input  AW  jump target
rom_data  input  DW  ROM read data; combinational ROM, valid same cycle as rom_addr
rom_addr  output  AW  ROM address, equals PC register directly
instr  output  DW/2  instruction register, upper half
oprnd  output  DW/2  instruction register, lower half
phase  output  1  0 = FETCH or IDLE, 1 = EXEC
ir_valid  output  1  high during EXEC; instr/oprnd are stable and valid
pc_wrap  output  1  one-cycle pulse; PC rolled from all-ones to zero on the previous edge

Behaviour:
- Reset (rst_n=0, asynchronous, immediate):
  - PC=0, instr=0, oprnd=0, state=IDLE, phase=0, ir_valid=0, pc_wrap=0, pending-step flag=0.
- Reset deassertion is taken at the next rising edge. Reset mid-EXEC discards the current instruction with no further effect.
- States: IDLE, FETCH, EXEC; 2-bit encoded, registered.
- IDLE:
  - Goes to FETCH if run=1 or step=1; otherwise stays.
  - load_pc=1 in IDLE sets PC <= load_addr. If it coincides with run/step, the load happens and FETCH starts from the new PC on the next cycle.
- FETCH (phase=0, ir_valid=0):
  - At the clock edge: {instr,oprnd} <= rom_data at the current rom_addr; PC <= PC+1 modulo 2^AW.
  - Always goes to EXEC. load_pc is ignored in FETCH.
- EXEC (phase=1, ir_valid=1, exactly one cycle):
  - If load_pc=1: PC <= load_addr (jump).
  - Next state is FETCH if run=1; otherwise IDLE (step mode ends after one pair).
- Latency: the ROM byte at address N appears on instr/oprnd one cycle after FETCH at PC=N. Free-running throughput is one instruction per 2 cycles.
- step while run=1 is ignored. step while not in IDLE is ignored; it is not queued.
- Dropping run during FETCH completes the pair (FETCH then EXEC), then goes to IDLE.
- Wrap-around: PC all-ones incremented becomes 0, and pc_wrap pulses high for the following cycle. A jump in EXEC never asserts pc_wrap.
- instr/oprnd hold their value outside FETCH edges, including in IDLE.
- All outputs are registered except rom_addr, which is the PC register itself.

Test Plan:
1. Reset, then run=1 with ROM[0..3]=8'hA5,8'h3C,8'h0F,8'hF0 -> phase toggles 0,1,0,1…; in EXEC cycles {instr,oprnd} = A/5, 3/C, 0/F, F/0; rom_addr steps 0,1,1,2,2,3…
2. run=0, single step pulse from IDLE at PC=0x004 -> exactly one FETCH+EXEC, ir_valid high for one cycle, return to IDLE with PC=0x005; a second step during EXEC is ignored.
3. Jump: load_pc=1, load_addr=12'h800 during EXEC of the instruction at 0x002 -> next FETCH uses rom_addr=0x800; load_pc asserted during FETCH has no effect.
4. Wrap: load_addr=12'hFFF in IDLE, then run -> FETCH at 0xFFF, PC becomes 0x000, pc_wrap=1 for exactly one cycle.
5. Async reset: assert rst_n=0 mid-EXEC between clock edges -> all outputs zero immediately; after release, fetch resumes from 0x000 only once run/step is applied.
6. Drop run during FETCH -> the pair completes (EXEC with valid data), then IDLE; PC holds, instr/oprnd hold the last value.

Source files
------------

// File: rtl/rom_fetch_unit.sv
// rom_fetch_unit: program counter and fetch stage in front of a combinational
// program ROM. Alternates FETCH/EXEC phases, latches each ROM byte into an
// instruction register split into instruction and operand nibbles, and
// supports free-running, single-step and jump operation.
module rom_fetch_unit #(
  parameter int AW = 12,
  parameter int DW = 8  // must be even: instr is the upper half, oprnd the lower half
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          step,
  input  logic          load_pc,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] rom_data,
  output logic [AW-1:0] rom_addr,
  output logic [DW/2-1:0] instr,
  output logic [DW/2-1:0] oprnd,
  output logic          phase,
  output logic          ir_valid,
  output logic          pc_wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_next;
  logic [DW-1:0] ir;
  logic [DW-1:0] ir_next;
  logic          wrap_next;

  // Next-state, PC and instruction-register update for the fetch sequencer
  always_comb begin
    next_state = state;
    pc_next    = pc;
    ir_next    = ir;
    wrap_next  = 1'b0;
    case (state)
      IDLE: begin
        if (load_pc) begin
          pc_next = load_addr;
        end
        if (run || step) begin
          next_state = FETCH;
        end
      end
      FETCH: begin
        ir_next    = rom_data;
        pc_next    = pc + AW'(1);
        wrap_next  = (pc == {AW{1'b1}});
        next_state = EXEC;
      end
      EXEC: begin
        if (load_pc) begin
          pc_next = load_addr;
        end
        next_state = run ? FETCH : IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, PC, IR and registered status outputs; phase/ir_valid are
  // registered from the next state so they carry no decode logic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= '0;
      ir       <= '0;
      phase    <= 1'b0;
      ir_valid <= 1'b0;
      pc_wrap  <= 1'b0;
    end else begin
      state    <= next_state;
      pc       <= pc_next;
      ir       <= ir_next;
      phase    <= (next_state == EXEC);
      ir_valid <= (next_state == EXEC);
      pc_wrap  <= wrap_next;
    end
  end

  assign rom_addr = pc;
  assign instr    = ir[DW-1:DW/2];
  assign oprnd    = ir[DW/2-1:0];

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Directed testbench for rom_fetch_unit with a behavioural combinational ROM.
module tb_rom_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        step;
  logic        load_pc;
  logic [11:0] load_addr;
  logic [7:0]  rom_data;
  logic [11:0] rom_addr;
  logic [3:0]  instr;
  logic [3:0]  oprnd;
  logic        phase;
  logic        ir_valid;
  logic        pc_wrap;

  logic [7:0]  rom [0:4095];
  int          checks;
  int          errors;

  rom_fetch_unit #(.AW(12), .DW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .step      (step),
    .load_pc   (load_pc),
    .load_addr (load_addr),
    .rom_data  (rom_data),
    .rom_addr  (rom_addr),
    .instr     (instr),
    .oprnd     (oprnd),
    .phase     (phase),
    .ir_valid  (ir_valid),
    .pc_wrap   (pc_wrap)
  );

  assign rom_data = rom[rom_addr];

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit so the run always terminates
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    run = 1'b0; step = 1'b0; load_pc = 1'b0; load_addr = 12'h000;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rom_addr !== 12'h000) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 000", rom_addr); end
    checks++;
    if ({instr, oprnd} !== 8'h00) begin errors++; $display("[TB] FAIL reset_ir: got %h expected 00", {instr, oprnd}); end
    checks++;
    if ({phase, ir_valid, pc_wrap} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {phase, ir_valid, pc_wrap}); end
    tick();
    tick();
    #3;
    rst_n = 1'b1;
    tick();
    checks++;
    if ({phase, rom_addr} !== 13'h0000) begin errors++; $display("[TB] FAIL reset_idle: got %h expected 0000", {phase, rom_addr}); end
  endtask

  task automatic test_run();
    logic [7:0] exp_bytes [4];
    exp_bytes[0] = 8'hA5; exp_bytes[1] = 8'h3C; exp_bytes[2] = 8'h0F; exp_bytes[3] = 8'hF0;
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({phase, ir_valid, rom_addr} !== {2'b00, 12'(i)}) begin errors++; $display("[TB] FAIL run_fetch%0d: got ph=%b v=%b addr=%h expected ph=0 v=0 addr=%h", i, phase, ir_valid, rom_addr, 12'(i)); end
      tick();
      checks++;
      if ({phase, ir_valid, rom_addr} !== {2'b11, 12'(i + 1)}) begin errors++; $display("[TB] FAIL run_exec%0d: got ph=%b v=%b addr=%h expected ph=1 v=1 addr=%h", i, phase, ir_valid, rom_addr, 12'(i + 1)); end
      checks++;
      if ({instr, oprnd} !== exp_bytes[i]) begin errors++; $display("[TB] FAIL run_ir%0d: got %h%h expected %h", i, instr, oprnd, exp_bytes[i]); end
    end
    run = 1'b0;
    tick();
    checks++;
    if ({phase, ir_valid, rom_addr, instr, oprnd} !== {2'b00, 12'h004, 8'hF0}) begin errors++; $display("[TB] FAIL run_stop: got ph=%b v=%b addr=%h ir=%h%h expected ph=0 v=0 addr=004 ir=f0", phase, ir_valid, rom_addr, instr, oprnd); end
  endtask

  task automatic test_step();
    step = 1'b1;
    tick();
    step = 1'b0;
    checks++;
    if ({phase, ir_valid, rom_addr} !== {2'b00, 12'h004}) begin errors++; $display("[TB] FAIL step_fetch: got ph=%b v=%b addr=%h expected ph=0 v=0 addr=004", phase, ir_valid, rom_addr); end
    tick();
    checks++;
    if ({phase, ir_valid, rom_addr, instr, oprnd} !== {2'b11, 12'h005, 8'h7E}) begin errors++; $display("[TB] FAIL step_exec: got ph=%b v=%b addr=%h ir=%h%h expected ph=1 v=1 addr=005 ir=7e", phase, ir_valid, rom_addr, instr, oprnd); end
    step = 1'b1;
    tick();
    step = 1'b0;
    checks++;
    if ({phase, ir_valid, rom_addr} !== {2'b00, 12'h005}) begin errors++; $display("[TB] FAIL step_idle: got ph=%b v=%b addr=%h expected ph=0 v=0 addr=005", phase, ir_valid, rom_addr); end
    tick();
    tick();
    checks++;
    if ({phase, ir_valid, rom_addr} !== {2'b00, 12'h005}) begin errors++; $display("[TB] FAIL step_not_queued: got ph=%b v=%b addr=%h expected ph=0 v=0 addr=005", phase, ir_valid, rom_addr); end
  endtask

  task automatic test_jump();
    load_pc = 1'b1; load_addr = 12'h002;
    tick();
    load_pc = 1'b0;
    checks++;
    if ({phase, rom_addr} !== {1'b0, 12'h002}) begin errors++; $display("[TB] FAIL jump_idle_load: got ph=%b addr=%h expected ph=0 addr=002", phase, rom_addr); end
    run = 1'b1;
    tick();
    tick();
    checks++;
    if ({phase, rom_addr, instr, oprnd} !== {1'b1, 12'h003, 8'h0F}) begin errors++; $display("[TB] FAIL jump_exec_src: got ph=%b addr=%h ir=%h%h expected ph=1 addr=003 ir=0f", phase, rom_addr, instr, oprnd); end
    load_pc = 1'b1; load_addr = 12'h800;
    tick();
    checks++;
    if ({phase, rom_addr} !== {1'b0, 12'h800}) begin errors++; $display("[TB] FAIL jump_target: got ph=%b addr=%h expected ph=0 addr=800", phase, rom_addr); end
    load_addr = 12'h123;
    tick();
    load_pc = 1'b0;
    run = 1'b0;
    checks++;
    if ({phase, rom_addr, instr, oprnd, pc_wrap} !== {1'b1, 12'h801, 8'h96, 1'b0}) begin errors++; $display("[TB] FAIL jump_fetch_ignore: got ph=%b addr=%h ir=%h%h wrap=%b expected ph=1 addr=801 ir=96 wrap=0", phase, rom_addr, instr, oprnd, pc_wrap); end
    tick();
    checks++;
    if ({phase, rom_addr} !== {1'b0, 12'h801}) begin errors++; $display("[TB] FAIL jump_idle: got ph=%b addr=%h expected ph=0 addr=801", phase, rom_addr); end
  endtask

  task automatic test_wrap();
    load_pc = 1'b1; load_addr = 12'hFFF; run = 1'b1;
    tick();
    load_pc = 1'b0;
    checks++;
    if ({phase, rom_addr, pc_wrap} !== {1'b0, 12'hFFF, 1'b0}) begin errors++; $display("[TB] FAIL wrap_fetch: got ph=%b addr=%h wrap=%b expected ph=0 addr=fff wrap=0", phase, rom_addr, pc_wrap); end
    tick();
    checks++;
    if ({phase, rom_addr, pc_wrap, instr, oprnd} !== {1'b1, 12'h000, 1'b1, 8'hC3}) begin errors++; $display("[TB] FAIL wrap_exec: got ph=%b addr=%h wrap=%b ir=%h%h expected ph=1 addr=000 wrap=1 ir=c3", phase, rom_addr, pc_wrap, instr, oprnd); end
    tick();
    checks++;
    if ({rom_addr, pc_wrap} !== {12'h000, 1'b0}) begin errors++; $display("[TB] FAIL wrap_pulse_end: got addr=%h wrap=%b expected addr=000 wrap=0", rom_addr, pc_wrap); end
    run = 1'b0;
    tick();
    checks++;
    if ({phase, rom_addr, pc_wrap} !== {1'b1, 12'h001, 1'b0}) begin errors++; $display("[TB] FAIL wrap_next_exec: got ph=%b addr=%h wrap=%b expected ph=1 addr=001 wrap=0", phase, rom_addr, pc_wrap); end
    tick();
  endtask

  task automatic test_async_reset();
    run = 1'b1;
    tick();
    tick();
    checks++;
    if ({phase, instr, oprnd} !== {1'b1, 8'h3C}) begin errors++; $display("[TB] FAIL areset_pre: got ph=%b ir=%h%h expected ph=1 ir=3c", phase, instr, oprnd); end
    #2;
    rst_n = 1'b0;
    run = 1'b0;
    #1;
    checks++;
    if ({rom_addr, instr, oprnd, phase, ir_valid, pc_wrap} !== 23'h0) begin errors++; $display("[TB] FAIL areset_immediate: got addr=%h ir=%h%h ph=%b v=%b wrap=%b expected all zero", rom_addr, instr, oprnd, phase, ir_valid, pc_wrap); end
    #3;
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if ({phase, rom_addr} !== {1'b0, 12'h000}) begin errors++; $display("[TB] FAIL areset_wait: got ph=%b addr=%h expected ph=0 addr=000", phase, rom_addr); end
    run = 1'b1;
    tick();
    tick();
    checks++;
    if ({phase, rom_addr, instr, oprnd} !== {1'b1, 12'h001, 8'hA5}) begin errors++; $display("[TB] FAIL areset_resume: got ph=%b addr=%h ir=%h%h expected ph=1 addr=001 ir=a5", phase, rom_addr, instr, oprnd); end
  endtask

  task automatic test_drop_run();
    tick();
    run = 1'b0;
    checks++;
    if ({phase, rom_addr} !== {1'b0, 12'h001}) begin errors++; $display("[TB] FAIL drop_fetch: got ph=%b addr=%h expected ph=0 addr=001", phase, rom_addr); end
    tick();
    checks++;
    if ({phase, ir_valid, rom_addr, instr, oprnd} !== {2'b11, 12'h002, 8'h3C}) begin errors++; $display("[TB] FAIL drop_exec: got ph=%b v=%b addr=%h ir=%h%h expected ph=1 v=1 addr=002 ir=3c", phase, ir_valid, rom_addr, instr, oprnd); end
    tick();
    tick();
    checks++;
    if ({phase, ir_valid, rom_addr, instr, oprnd} !== {2'b00, 12'h002, 8'h3C}) begin errors++; $display("[TB] FAIL drop_idle_hold: got ph=%b v=%b addr=%h ir=%h%h expected ph=0 v=0 addr=002 ir=3c", phase, ir_valid, rom_addr, instr, oprnd); end
  endtask

  // Test sequence; each scenario leaves the DUT where the next one starts
  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[0] = 8'hA5; rom[1] = 8'h3C; rom[2] = 8'h0F; rom[3] = 8'hF0;
    rom[4] = 8'h7E; rom[12'h800] = 8'h96; rom[12'hFFF] = 8'hC3;
    test_reset();
    test_run();
    test_step();
    test_jump();
    test_wrap();
    test_async_reset();
    test_drop_run();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
